sqdet_multi: RTL

Parametrised multi-channel serial sequence detector, the next generation of the single-pattern 8-bit detector.
- Shifts a qualified serial bit stream into a PW-bit history register.
- Compares the history against NP independently programmable, bit-maskable patterns.
- Produces a registered one-cycle detect pulse and a saturating match counter per channel.
- Supports overlapping or non-overlapping detection.
- Sits between a serial front end and status/control logic that polls the counts.

---
 rtl/sqdet_pkg.sv | 22 ++
 rtl/sqdet_chan.sv | 49 ++++
 rtl/sqdet_multi.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sqdet_pkg.sv
// Shared types and constants for the sqdet_multi sequence detector.
package sqdet_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int PW_DEFAULT = 8;
    localparam int NP_DEFAULT = 2;
    localparam int CW_DEFAULT = 4;

    // Width of a counter that must reach the value pw.
    function automatic int fill_width(input int pw);
        return $clog2(pw + 1);
    endfunction

    function automatic int id_width(input int np);
        return (np > 1) ? $clog2(np) : 1;
    endfunction

endpackage

// File: rtl/sqdet_chan.sv
// One pattern channel: masked compare, registered detect pulse and a
// saturating match counter in which a synchronous clear beats an increment.
module sqdet_chan
    import sqdet_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          win,
    input  logic [PW-1:0] hist_nx,
    input  logic [PW-1:0] setd,
    input  logic [PW-1:0] mask,
    input  logic          clr_cnt,
    output logic          match,
    output logic          dc,
    output logic [CW-1:0] c
);

    logic          dc_q, dc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // An all-zero mask would match everything, so it disables the channel.
        match = win && (mask != '0) && (((hist_nx ^ setd) & mask) == '0);
        dc_d  = match;
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dc_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            dc_q  <= dc_d;
            cnt_q <= cnt_d;
        end
    end

    assign dc = dc_q;
    assign c  = cnt_q;

endmodule

// File: rtl/sqdet_multi.sv
// Multi-channel serial sequence detector. Optional SQDET_HITLOG_EN adds
// hit_any/hit_id outputs reporting the lowest-index matching channel.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_FILL | collecting PW fresh valid bits; matches only on the PW-th
//   ST_RUN  | history full; every valid bit may produce a match
module sqdet_multi
    import sqdet_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int NP = NP_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   en,
    input  logic                   ds,
    input  logic [NP*PW-1:0]       setd,
    input  logic [NP*PW-1:0]       mask,
    input  logic                   overlap,
    input  logic                   clr_cnt,
    output logic [NP-1:0]          dc,
    output logic [NP*CW-1:0]       c,
    output logic                   armed
`ifdef SQDET_HITLOG_EN
    ,
    output logic                   hit_any,
    output logic [id_width(NP)-1:0] hit_id
`endif
);

    localparam int FW = fill_width(PW);

    state_e          state_q, state_d;
    // The oldest bit is only ever needed combinationally, so it is not stored.
    logic [PW-2:0]   hist_q, hist_d;
    logic [PW-1:0]   hist_nx;
    logic [FW-1:0]   fill_q, fill_d;
    logic            last_fill;
    logic            win;
    logic [NP-1:0]   match;

    always_comb begin
        hist_nx   = {hist_q, ds};
        last_fill = (state_q == ST_FILL) && (fill_q == FW'(PW - 1));
        win       = en && (last_fill || (state_q == ST_RUN));
        hist_d    = hist_q;
        fill_d    = fill_q;
        state_d   = state_q;
        if (en) begin
            hist_d = hist_nx[PW-2:0];
            if (state_q == ST_FILL) begin
                fill_d = fill_q + FW'(1);
                if (last_fill) begin
                    state_d = ST_RUN;
                end
            end
            if ((|match) && !overlap) begin
                state_d = ST_FILL;
                fill_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    assign armed = (state_q == ST_RUN);

    for (genvar k = 0; k < NP; k++) begin : g_chan
        sqdet_chan #(
            .PW (PW),
            .CW (CW)
        ) u_chan (
            .clk     (clk),
            .clrn    (clrn),
            .win     (win),
            .hist_nx (hist_nx),
            .setd    (setd[k*PW +: PW]),
            .mask    (mask[k*PW +: PW]),
            .clr_cnt (clr_cnt),
            .match   (match[k]),
            .dc      (dc[k]),
            .c       (c[k*CW +: CW])
        );
    end

`ifdef SQDET_HITLOG_EN
    localparam int IW = id_width(NP);

    logic          hit_any_q, hit_any_d;
    logic [IW-1:0] hit_id_q, hit_id_d;

    always_comb begin
        hit_any_d = |match;
        hit_id_d  = hit_id_q;
        // Descending scan so the lowest matching index is the last written.
        for (int k = NP - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit_id_d = IW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hit_any_q <= 1'b0;
            hit_id_q  <= '0;
        end else begin
            hit_any_q <= hit_any_d;
            hit_id_q  <= hit_id_d;
        end
    end

    assign hit_any = hit_any_q;
    assign hit_id  = hit_id_q;
`endif

endmodule
